motor_ramp_ctrl: RTL and testbench
==================================

MOTOR_RAMP_CTRL -- requirements
Module: motor_ramp_ctrl

Interface
REQ-001 SHALL have parameter STEP, default 16: duty change per ramp tick, range 1..4095.
REQ-002 SHALL have parameter TICK_DIV, default 3125: clocks per ramp tick (1 kHz at 3125 kHz), minimum 1.
REQ-003 SHALL have parameter DEADTIME, default 3125: clocks held at zero duty before a direction flip, minimum 1.
REQ-004 SHALL have port clk_3125K  input  1  sole clock, 3125 kHz; all logic on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port cmd_valid  input  1  speed command present.
REQ-007 SHALL have port cmd_speed  input  13  signed two's-complement speed command; sign selects direction, magnitude selects duty.
REQ-008 SHALL have port cmd_ready  output  1  command accepted on cmd_valid && cmd_ready.
REQ-009 SHALL have port duty_cycle  output  12  registered duty value for the downstream PWM stage.
REQ-010 SHALL have port forward  output  1  registered direction for the PWM stage (1 = forward).
REQ-011 SHALL have port at_target  output  1  high when duty_cycle and forward equal the accepted target.

Function
REQ-012 SHALL clamp cmd_speed -4096 to magnitude 4095; target_dir = (cmd_speed >= 0); target_mag = |cmd_speed|.
REQ-013 SHALL, when target_mag = 0, keep target_dir equal to the current forward, so no flip occurs.
REQ-014 SHALL latch target on every accepted command; the latest accepted command always replaces the earlier one, including mid-ramp.
REQ-015 SHALL drive cmd_ready low only in state DEAD, and high in all other states.
REQ-016 SHALL run a free-running tick counter 0..TICK_DIV-1 that wraps to 0, with tick asserted on the wrap cycle.
REQ-017 SHALL implement states IDLE, RAMP and DEAD.
REQ-018 IDLE: outputs equal the target and at_target = 1; an accepted command that differs from the outputs SHALL move to RAMP on the next cycle.
REQ-019 RAMP, direction matches the target: on each tick, duty moves toward target_mag by min(STEP, |difference|); when equal, the state SHALL go to IDLE.
REQ-020 RAMP, direction differs: on each tick, duty decreases by min(STEP, duty); when duty = 0, the state SHALL go to DEAD.
REQ-021 DEAD: duty SHALL be held at 0 for DEADTIME clocks, after which forward toggles and the state goes to RAMP, all in the same cycle.
REQ-022 SHALL perform duty arithmetic in 13 bits, with results saturated to 0..4095 and no wrap-around.
REQ-023 SHALL update duty_cycle only on tick cycles, registered, with one-clock latency from the tick.
REQ-024 SHALL make a command accepted on a tick cycle affect duty from the next tick onward.
REQ-025 SHALL compute at_target combinationally from registered state and target, with no extra latency.
REQ-026 SHALL never change forward while duty_cycle is nonzero.

Reset
REQ-027 SHALL, on reset high at a clock edge, set duty_cycle = 0, forward = 1, target_mag = 0, target_dir = 1, state = IDLE, tick counter = 0, DEAD counter = 0, cmd_ready = 1, at_target = 1.
REQ-028 SHALL give reset priority over commands, ticks and brake; reset mid-ramp or mid-DEAD SHALL take effect on the next edge and abandon the operation.

Configuration
REQ-029 SHALL, when macro MOTOR_RAMP_BRAKE_EN is defined, add port brake  input  1.
REQ-030 With MOTOR_RAMP_BRAKE_EN, brake high SHALL force duty_cycle = 0 on the next clock regardless of tick, set target_mag = 0, keep forward, enter IDLE, and hold cmd_ready low while brake is high.
REQ-031 Without MOTOR_RAMP_BRAKE_EN, the brake port SHALL NOT exist, and zero duty SHALL be reached only by ramping.

Verification (STEP=16, TICK_DIV=4, DEADTIME=8)
REQ-032 Reset, then cmd_speed=+40 accepted -> duty 16, 32, 40 on three successive ticks (4 clocks apart); forward stays 1; at_target rises with the 40.
REQ-033 From +40, cmd_speed=-20 -> duty 24, 8, 0 on ticks, then cmd_ready low for 8 clocks, then forward=0 -> duty 16, 20; forward never toggles while duty is nonzero.
REQ-034 cmd_speed=-4096 from 0 -> target_mag 4095; duty steps by 16 and ends exactly 4095 with no wrap.
REQ-035 At duty 32 ramping to 100, cmd_speed=+10 accepted -> next tick duty 16, following tick 10, then IDLE.
REQ-036 Reset asserted during DEAD -> next clock duty 0, forward 1, cmd_ready 1, IDLE.
REQ-037 With MOTOR_RAMP_BRAKE_EN, brake pulsed at duty 200 -> duty 0 next clock, forward unchanged, cmd_ready low while brake is high.

Source files
------------

// File: rtl/motor_ramp_ctrl.sv
// motor_ramp_ctrl: ramps a signed speed command into PWM duty + direction.
// Optional brake input is added when MOTOR_RAMP_BRAKE_EN is defined.
module motor_ramp_ctrl #(
  parameter int STEP     = 16,
  parameter int TICK_DIV = 3125,
  parameter int DEADTIME = 3125
) (
  input  logic        clk_3125K,
  input  logic        reset,
`ifdef MOTOR_RAMP_BRAKE_EN
  input  logic        brake,
`endif
  input  logic        cmd_valid,
  input  logic [12:0] cmd_speed,
  output logic        cmd_ready,
  output logic [11:0] duty_cycle,
  output logic        forward,
  output logic        at_target
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DEADTIME > 1) ? $clog2(DEADTIME) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DW-1:0] DEAD_LAST = DW'(DEADTIME - 1);
  localparam logic [12:0]   STEP13    = 13'(STEP);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RAMP,
    S_DEAD
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [TW-1:0] r_tick_cnt;
  logic [DW-1:0] r_dead_cnt;
  logic [11:0]   r_duty;
  logic [11:0]   r_tmag;
  logic          r_fwd;
  logic          r_tdir;

  logic          w_brake;
  logic          w_tick;
  logic          w_accept;
  logic          w_dead_done;
  logic          w_dir_match;
  logic          w_at_tgt;
  logic          w_cmd_neg;
  logic [12:0]   w_abs;
  logic [11:0]   w_new_mag;
  logic          w_new_dir;
  logic          w_new_diff;
  logic [12:0]   w_duty13;
  logic [12:0]   w_tmag13;
  logic [12:0]   w_gap;
  logic [12:0]   w_step;
  logic [12:0]   w_sum;
  logic [11:0]   w_duty_ramp;

`ifdef MOTOR_RAMP_BRAKE_EN
  assign w_brake = brake;
`else
  assign w_brake = 1'b0;
`endif

  assign w_tick      = (r_tick_cnt == TICK_LAST);
  assign w_dead_done = (r_dead_cnt == DEAD_LAST);
  assign w_accept    = cmd_valid && cmd_ready;

  // -4096 has no positive twin in 13 bits; clamp its magnitude to 4095
  assign w_cmd_neg = cmd_speed[12];
  assign w_abs     = w_cmd_neg ? (13'd0 - cmd_speed) : cmd_speed;
  assign w_new_mag = w_abs[12] ? 12'hFFF : w_abs[11:0];
  assign w_new_dir = (w_new_mag == 12'd0) ? r_fwd : !w_cmd_neg;
  assign w_new_diff = (w_new_mag != r_duty) || (w_new_dir != r_fwd);

  assign w_dir_match = (r_fwd == r_tdir);
  assign w_at_tgt    = w_dir_match && (r_duty == r_tmag);

  assign w_duty13 = {1'b0, r_duty};
  assign w_tmag13 = {1'b0, r_tmag};

  always_comb begin
    w_gap       = 13'd0;
    w_step      = 13'd0;
    w_sum       = w_duty13;
    w_duty_ramp = r_duty;
    if (w_dir_match) begin
      if (w_tmag13 >= w_duty13) begin
        w_gap  = w_tmag13 - w_duty13;
        w_step = (w_gap < STEP13) ? w_gap : STEP13;
        w_sum  = w_duty13 + w_step;
        w_duty_ramp = w_sum[12] ? 12'hFFF : w_sum[11:0];
      end else begin
        w_gap  = w_duty13 - w_tmag13;
        w_step = (w_gap < STEP13) ? w_gap : STEP13;
        w_sum  = w_duty13 - w_step;
        w_duty_ramp = w_sum[11:0];
      end
    end else begin
      w_step = (w_duty13 < STEP13) ? w_duty13 : STEP13;
      w_sum  = w_duty13 - w_step;
      w_duty_ramp = w_sum[11:0];
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if ((w_accept && w_new_diff) || !w_at_tgt)
          w_state_nxt = S_RAMP;
      end
      S_RAMP: begin
        // a command landing this cycle may retarget; decide next cycle
        if (!w_accept) begin
          if (w_at_tgt)
            w_state_nxt = S_IDLE;
          else if (!w_dir_match && r_duty == 12'd0)
            w_state_nxt = S_DEAD;
        end
      end
      S_DEAD: begin
        if (w_dead_done)
          w_state_nxt = S_RAMP;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_3125K) begin
    if (reset)
      r_state <= S_IDLE;
    else if (w_brake)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_3125K) begin
    if (reset)
      r_tick_cnt <= '0;
    else if (w_tick)
      r_tick_cnt <= '0;
    else
      r_tick_cnt <= r_tick_cnt + TW'(1);
  end

  always_ff @(posedge clk_3125K) begin
    if (reset) begin
      r_duty     <= 12'd0;
      r_fwd      <= 1'b1;
      r_tmag     <= 12'd0;
      r_tdir     <= 1'b1;
      r_dead_cnt <= '0;
    end else if (w_brake) begin
      r_duty     <= 12'd0;
      r_tmag     <= 12'd0;
      r_tdir     <= r_fwd;
      r_dead_cnt <= '0;
    end else begin
      if (w_accept) begin
        r_tmag <= w_new_mag;
        r_tdir <= w_new_dir;
      end
      if (r_state == S_RAMP && w_tick)
        r_duty <= w_duty_ramp;
      if (r_state == S_DEAD) begin
        if (w_dead_done) begin
          r_dead_cnt <= '0;
          r_fwd      <= !r_fwd;
        end else begin
          r_dead_cnt <= r_dead_cnt + DW'(1);
        end
      end
    end
  end

  assign cmd_ready  = (r_state != S_DEAD) && !w_brake;
  assign duty_cycle = r_duty;
  assign forward    = r_fwd;
  assign at_target  = w_at_tgt;

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// tb_motor_ramp_ctrl: vector-table and directed checks of motor_ramp_ctrl
// with STEP=16, TICK_DIV=4, DEADTIME=8.
module tb_motor_ramp_ctrl;

  logic        clk;
  logic        reset;
  logic        cmd_valid;
  logic [12:0] cmd_speed;
  logic        cmd_ready;
  logic [11:0] duty_cycle;
  logic        forward;
  logic        at_target;
`ifdef MOTOR_RAMP_BRAKE_EN
  logic        brake;
`endif

  int n_checks;
  int n_pass;
  int cyc;
  logic prev_fwd;

  motor_ramp_ctrl #(
    .STEP(16),
    .TICK_DIV(4),
    .DEADTIME(8)
  ) dut (
    .clk_3125K(clk),
    .reset(reset),
`ifdef MOTOR_RAMP_BRAKE_EN
    .brake(brake),
`endif
    .cmd_valid(cmd_valid),
    .cmd_speed(cmd_speed),
    .cmd_ready(cmd_ready),
    .duty_cycle(duty_cycle),
    .forward(forward),
    .at_target(at_target)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        cmd;
    logic [12:0] speed;
    logic [11:0] duty;
    logic        fwd;
    logic        at;
  } vec_t;

  vec_t vecs[14];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp)
      n_pass++;
    else
      $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc = reset ? 0 : cyc + 1;
  endtask

  task automatic next_tick();
    do step(); while (cyc % 4 != 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic send_cmd(input logic [12:0] s);
    int n;
    logic rdy;
    cmd_valid = 1'b1;
    cmd_speed = s;
    n = 0;
    do begin
      rdy = cmd_ready;
      step();
      n++;
    end while (!rdy && n < 50);
    cmd_valid = 1'b0;
    check("cmd_accept", int'(rdy), 1);
  endtask

  task automatic apply_vec(input int i);
    if (vecs[i].rst) do_reset();
    if (vecs[i].cmd) send_cmd(vecs[i].speed);
    next_tick();
    check($sformatf("v%0d_duty", i), int'(duty_cycle), int'(vecs[i].duty));
    check($sformatf("v%0d_fwd", i), int'(forward), int'(vecs[i].fwd));
    check($sformatf("v%0d_at", i), int'(at_target), int'(vecs[i].at));
  endtask

  // forward may only change while duty is zero
  always @(negedge clk) begin
    if (forward !== prev_fwd) begin
      check("fwd_flip_at_zero", int'(duty_cycle), 0);
      prev_fwd = forward;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lowcnt;
    int n;
    int exp_d;
    logic mism;
    n_checks  = 0;
    n_pass    = 0;
    cyc       = 0;
    prev_fwd  = 1'b1;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_speed = '0;
`ifdef MOTOR_RAMP_BRAKE_EN
    brake     = 1'b0;
`endif

    vecs[0]  = '{1'b1, 1'b1, 13'd40,     12'd16, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 13'd0,      12'd32, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 13'd0,      12'd40, 1'b1, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 13'd0,      12'd40, 1'b1, 1'b1};
    vecs[4]  = '{1'b0, 1'b1, 13'(-20),   12'd24, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 13'd0,      12'd8,  1'b1, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 13'd0,      12'd0,  1'b1, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 13'd0,      12'd16, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b0, 13'd0,      12'd20, 1'b0, 1'b1};
    vecs[9]  = '{1'b1, 1'b1, 13'd100,    12'd16, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 13'd0,      12'd32, 1'b1, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 13'd10,     12'd16, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 13'd0,      12'd10, 1'b1, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 13'd0,      12'd10, 1'b1, 1'b1};

    do_reset();
    check("rst_duty", int'(duty_cycle), 0);
    check("rst_fwd", int'(forward), 1);
    check("rst_ready", int'(cmd_ready), 1);
    check("rst_at", int'(at_target), 1);

    for (int i = 0; i <= 6; i++) apply_vec(i);

    // duty reached zero: ready stays high one cycle, then DEAD for 8
    check("ramp0_ready", int'(cmd_ready), 1);
    lowcnt = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (!cmd_ready) lowcnt++;
      else break;
    end
    check("dead_len", lowcnt, 8);
    check("dead_exit_fwd", int'(forward), 0);
    check("dead_exit_duty", int'(duty_cycle), 0);

    for (int i = 7; i <= 13; i++) apply_vec(i);
    check("idle_ready", int'(cmd_ready), 1);

    // full-scale reverse: -4096 clamps to 4095
    do_reset();
    send_cmd(13'h1000);
    n = 0;
    while (forward && n < 40) begin
      step();
      n++;
    end
    check("fs_flip", int'(forward), 0);
    exp_d = 0;
    mism = 1'b0;
    for (int t = 0; t < 256; t++) begin
      next_tick();
      exp_d = (exp_d + 16 > 4095) ? 4095 : exp_d + 16;
      if (int'(duty_cycle) != exp_d && !mism) begin
        check($sformatf("fs_tick%0d", t), int'(duty_cycle), exp_d);
        mism = 1'b1;
      end
    end
    check("fs_final", int'(duty_cycle), 4095);
    check("fs_at", int'(at_target), 1);
    next_tick();
    check("fs_hold", int'(duty_cycle), 4095);

    // reset in the middle of DEAD
    do_reset();
    send_cmd(13'(-50));
    n = 0;
    while (cmd_ready && n < 20) begin
      step();
      n++;
    end
    check("dead_enter", int'(cmd_ready), 0);
    step();
    step();
    step();
    reset = 1'b1;
    step();
    check("dr_duty", int'(duty_cycle), 0);
    check("dr_fwd", int'(forward), 1);
    check("dr_ready", int'(cmd_ready), 1);
    check("dr_at", int'(at_target), 1);
    reset = 1'b0;
    next_tick();
    next_tick();
    check("dr_stay_duty", int'(duty_cycle), 0);
    check("dr_stay_fwd", int'(forward), 1);

`ifdef MOTOR_RAMP_BRAKE_EN
    do_reset();
    send_cmd(13'd200);
    for (int t = 0; t < 13; t++) next_tick();
    check("bk_pre_duty", int'(duty_cycle), 200);
    brake = 1'b1;
    #1;
    check("bk_ready_lo", int'(cmd_ready), 0);
    step();
    check("bk_duty", int'(duty_cycle), 0);
    check("bk_fwd", int'(forward), 1);
    check("bk_ready_hold", int'(cmd_ready), 0);
    brake = 1'b0;
    #1;
    check("bk_ready_hi", int'(cmd_ready), 1);
    check("bk_at", int'(at_target), 1);
    next_tick();
    check("bk_stay", int'(duty_cycle), 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
